// File: rtl/ov7670_transmitter.sv
// ov7670_transmitter: OV7670-style camera source that drives PCLK/VSYNC/HREF
// and byte-serial RGB565 pixels read from a 1-cycle-latency pixel port.
// Ports:
//   i_clk, i_reset      system clock, synchronous active-high reset
//   i_start, i_stop     begin streaming / finish current frame then idle
//   o_busy              high while frames are being produced
//   o_frame_done        one-cycle pulse at the end of every frame
//   o_PCLK, o_VS, o_HS  sensor pixel clock, VSYNC, HREF
//   o_DATA              sensor byte (high byte of a pixel first)
//   o_rd_en             pixel read strobe, with o_rd_h_addr/o_rd_v_addr
//   i_rd_data           pixel word, valid one i_clk after o_rd_en
// VS_LINES, VBP_LINES, VFP_LINES and H_BLANK are assumed to be at least 1.
module ov7670_transmitter #(
   parameter int DATA_WIDTH = 8,
   parameter int H_WIDTH    = 320,
   parameter int V_WIDTH    = 240,
   parameter int PXL_WIDTH  = 16,
   parameter int H_BLANK    = 144,
   parameter int VS_LINES   = 3,
   parameter int VBP_LINES  = 17,
   parameter int VFP_LINES  = 10
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic                       i_stop,
   output logic                       o_busy,
   output logic                       o_frame_done,
   output logic                       o_PCLK,
   output logic                       o_VS,
   output logic                       o_HS,
   output logic [DATA_WIDTH-1:0]      o_DATA,
   output logic                       o_rd_en,
   output logic [$clog2(H_WIDTH):0]   o_rd_h_addr,
   output logic [$clog2(V_WIDTH):0]   o_rd_v_addr,
   input  logic [PXL_WIDTH-1:0]       i_rd_data
);

   localparam int LINE = 2 * H_WIDTH + H_BLANK;
   localparam int HW   = $clog2(LINE);
   localparam int MAXL = VS_LINES + VBP_LINES + V_WIDTH + VFP_LINES;
   localparam int VW   = $clog2(MAXL + 1);
   localparam int HA   = $clog2(H_WIDTH) + 1;
   localparam int VA   = $clog2(V_WIDTH) + 1;

   localparam logic [HW-1:0] H_LAST     = HW'(LINE - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(2 * H_WIDTH);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(2 * H_WIDTH - 1);
   localparam logic [VW-1:0] VS_LAST    = VW'(VS_LINES - 1);
   localparam logic [VW-1:0] VBP_LAST   = VW'(VBP_LINES - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_WIDTH - 1);
   localparam logic [VW-1:0] VFP_LAST   = VW'(VFP_LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBP,
      S_ACTIVE,
      S_VFP
   } state_t;

   state_t                r_state;
   logic                  r_ph;
   logic [HW-1:0]         r_h;
   logic [VW-1:0]         r_v;
   logic                  r_stop;
   logic                  r_rd_en_d;
   logic [PXL_WIDTH-1:0]  r_pix;

   state_t                w_state_n;
   state_t                w_adv;
   logic                  w_ph_n;
   logic [HW-1:0]         w_h_n;
   logic [HW-1:0]         w_hp;
   logic [VW-1:0]         w_v_n;
   logic [VW-1:0]         w_last_v;
   logic                  w_done;
   logic                  w_upd;
   logic                  w_hs_n;
   logic [DATA_WIDTH-1:0] w_data_n;
   logic                  w_fetch;
   logic [HA-1:0]         w_fh;
   logic [VA-1:0]         w_fv;

   // last line index and successor of each frame region
   always_comb begin
      w_last_v = '0;
      w_adv    = S_IDLE;
      unique case (r_state)
         S_VSYNC: begin
            w_last_v = VS_LAST;
            w_adv    = S_VBP;
         end
         S_VBP: begin
            w_last_v = VBP_LAST;
            w_adv    = S_ACTIVE;
         end
         S_ACTIVE: begin
            w_last_v = V_LAST;
            w_adv    = S_VFP;
         end
         S_VFP: begin
            w_last_v = VFP_LAST;
            w_adv    = (r_stop || i_stop) ? S_IDLE : S_VSYNC;
         end
         default: begin
            w_last_v = '0;
            w_adv    = S_IDLE;
         end
      endcase
   end

   // next state; a tick completes on the cycle ph is 1
   always_comb begin
      w_state_n = r_state;
      w_ph_n    = r_ph;
      w_h_n     = r_h;
      w_v_n     = r_v;
      w_done    = 1'b0;
      if (r_state == S_IDLE) begin
         w_ph_n = 1'b0;
         if (i_start) begin
            w_state_n = S_VSYNC;
            w_h_n     = '0;
            w_v_n     = '0;
         end
      end else begin
         w_ph_n = ~r_ph;
         if (r_ph) begin
            if (r_h == H_LAST) begin
               w_h_n = '0;
               if (r_v == w_last_v) begin
                  w_v_n     = '0;
                  w_state_n = w_adv;
                  w_done    = (r_state == S_VFP);
               end else begin
                  w_v_n = r_v + VW'(1);
               end
            end else begin
               w_h_n = r_h + HW'(1);
            end
         end
      end
   end

   // outputs only move at tick boundaries (PCLK falling edge)
   assign w_upd  = (r_state == S_IDLE) || r_ph;
   assign w_hs_n = (w_state_n == S_ACTIVE) && (w_h_n < H_ACT);
   assign w_hp   = w_h_n + HW'(1);

   // high byte comes straight from the read port the cycle it is valid;
   // the word is kept in r_pix for the low byte one tick later
   always_comb begin
      w_data_n = '0;
      if (w_hs_n) begin
         if (w_h_n[0])
            w_data_n = r_pix[DATA_WIDTH-1:0];
         else
            w_data_n = i_rd_data[PXL_WIDTH-1:DATA_WIDTH];
      end
   end

   // pixel p is fetched at the start of tick 2p-1; pixel 0 of a line
   // in the last tick of the previous line (blank or VBP)
   always_comb begin
      w_fetch = 1'b0;
      w_fh    = '0;
      w_fv    = '0;
      if (r_ph && r_state != S_IDLE) begin
         if (w_state_n == S_ACTIVE && w_h_n[0] &&
             w_h_n < H_ACT_LAST) begin
            w_fetch = 1'b1;
            w_fh    = HA'(w_hp >> 1);
            w_fv    = VA'(w_v_n);
         end else if (w_h_n == H_LAST) begin
            if (w_state_n == S_ACTIVE && w_v_n != V_LAST) begin
               w_fetch = 1'b1;
               w_fv    = VA'(w_v_n + VW'(1));
            end else if (w_state_n == S_VBP &&
                         w_v_n == VBP_LAST) begin
               w_fetch = 1'b1;
               w_fv    = '0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_ph         <= 1'b0;
         r_h          <= '0;
         r_v          <= '0;
         r_stop       <= 1'b0;
         r_rd_en_d    <= 1'b0;
         r_pix        <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_VS         <= 1'b0;
         o_HS         <= 1'b0;
         o_DATA       <= '0;
         o_rd_en      <= 1'b0;
         o_rd_h_addr  <= '0;
         o_rd_v_addr  <= '0;
      end else begin
         r_state      <= w_state_n;
         r_ph         <= w_ph_n;
         r_h          <= w_h_n;
         r_v          <= w_v_n;
         r_stop       <= (w_state_n == S_IDLE) ? 1'b0 : (r_stop | i_stop);
         o_busy       <= (w_state_n != S_IDLE);
         o_frame_done <= w_done;
         o_rd_en      <= w_fetch;
         r_rd_en_d    <= o_rd_en;
         if (w_fetch) begin
            o_rd_h_addr <= w_fh;
            o_rd_v_addr <= w_fv;
         end
         if (r_rd_en_d)
            r_pix <= i_rd_data;
         if (w_upd) begin
            o_VS   <= (w_state_n == S_VSYNC);
            o_HS   <= w_hs_n;
            o_DATA <= w_data_n;
         end
      end
   end

   assign o_PCLK = r_ph;

endmodule

// File: tb/tb_ov7670_transmitter.sv
// tb_ov7670_transmitter: small-frame bench with a random pixel memory and
// a frame-level reference model of sync timing, fetch order and byte order.
module tb_ov7670_transmitter;

   localparam int DW   = 8;
   localparam int HWD  = 4;
   localparam int VWD  = 3;
   localparam int HB   = 4;
   localparam int VSL  = 1;
   localparam int VBPL = 1;
   localparam int VFPL = 1;
   localparam int LINE = 2 * HWD + HB;
   localparam int FRAME_CYC = (VSL + VBPL + VWD + VFPL) * LINE * 2;
   localparam int HA = $clog2(HWD) + 1;
   localparam int VA = $clog2(VWD) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          busy, done, pclk, vs, hs, rd_en;
   logic [DW-1:0] data;
   logic [HA-1:0] rd_h;
   logic [VA-1:0] rd_v;
   logic [15:0]   rd_data = 16'h0;
   logic [15:0]   mem [0:VWD-1][0:HWD-1];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ov7670_transmitter #(
      .DATA_WIDTH(DW), .H_WIDTH(HWD), .V_WIDTH(VWD), .PXL_WIDTH(16),
      .H_BLANK(HB), .VS_LINES(VSL), .VBP_LINES(VBPL), .VFP_LINES(VFPL)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
      .o_busy(busy), .o_frame_done(done), .o_PCLK(pclk),
      .o_VS(vs), .o_HS(hs), .o_DATA(data), .o_rd_en(rd_en),
      .o_rd_h_addr(rd_h), .o_rd_v_addr(rd_v), .i_rd_data(rd_data)
   );

   // pixel memory with one cycle of read latency
   always @(posedge clk) begin
      if (rd_en) begin
         if (int'(rd_h) < HWD && int'(rd_v) < VWD)
            rd_data <= mem[int'(rd_v)][int'(rd_h)];
         else
            rd_data <= 16'hDEAD;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pclk"}, 32'(pclk), 0);
      chk({tag, "_vs"}, 32'(vs), 0);
      chk({tag, "_hs"}, 32'(hs), 0);
      chk({tag, "_data"}, 32'(data), 0);
      chk({tag, "_rden"}, 32'(rd_en), 0);
      chk({tag, "_rdh"}, 32'(rd_h), 0);
      chk({tag, "_rdv"}, 32'(rd_v), 0);
   endtask

   // start streaming and check every frame until the source goes idle
   task automatic watch(input bit with_stop, input int stop_after,
                        input int glitch_at, input int exp_frames);
      int frames = 0, vs_rise = 0, last_done = -1;
      int vs_hi = 0, lines = 0, k = 0, reads = 0;
      bit stopped = 0;
      logic pv_vs = 0, pv_hs = 0, pv_pclk = 0;
      logic [15:0] px;
      logic [7:0] eb;
      int budget = (exp_frames + 1) * FRAME_CYC + 200;
      for (int r = 0; r < VWD; r++)
         for (int c = 0; c < HWD; c++)
            mem[r][c] = 16'($urandom);
      @(negedge clk);
      start = 1'b1;
      stop  = with_stop;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
         if (cyc == 1) begin
            chk("lat_busy", 32'(busy), 1);
            chk("lat_vs", 32'(vs), 1);
            chk("lat_pclk0", 32'(pclk), 0);
         end
         if (cyc == 2)
            chk("lat_pclk1", 32'(pclk), 1);
         if (cyc == glitch_at)
            start = 1'b1;
         if (!with_stop && !stopped && frames == stop_after &&
             cyc - last_done == 60) begin
            stop = 1'b1;
            stopped = 1;
         end
         if (done) begin
            chk("frame_len", 32'(cyc - vs_rise), 32'(FRAME_CYC));
            chk("vs_cycles", 32'(vs_hi), 32'(2 * VSL * LINE));
            chk("href_lines", 32'(lines), 32'(VWD));
            chk("reads", 32'(reads), 32'(HWD * VWD));
            frames++;
            last_done = cyc;
            vs_hi = 0;
            lines = 0;
            reads = 0;
         end
         if (vs && !pv_vs) begin
            vs_rise = cyc;
            if (last_done >= 0)
               chk("no_gap", 32'(cyc), 32'(last_done));
         end
         if (vs)
            vs_hi++;
         if (rd_en) begin
            chk("rd_h", 32'(rd_h), 32'(reads % HWD));
            chk("rd_v", 32'(rd_v), 32'(reads / HWD));
            if (rd_h == '0)
               chk("rd0_hs", 32'(hs), 0);
            reads++;
         end
         if (hs && pclk && !pv_pclk) begin
            if (lines < VWD && k < 2 * HWD)
               px = mem[lines][k / 2];
            else
               px = 16'hDEAD;
            eb = (k % 2 == 1) ? px[7:0] : px[15:8];
            chk("byte", 32'(data), 32'(eb));
            k++;
         end
         if (!hs)
            chk("data_idle", 32'(data), 0);
         if (!hs && pv_hs) begin
            chk("href_len", 32'(k), 32'(2 * HWD));
            lines++;
            k = 0;
         end
         pv_vs = vs;
         pv_hs = hs;
         pv_pclk = pclk;
         if (!busy)
            break;
      end
      chk("frames", 32'(frames), 32'(exp_frames));
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_pclk", 32'(pclk), 0);
   endtask

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("idle");

      // start and stop together: exactly one frame
      watch(1'b1, -1, -1, 1);

      // streaming; stray start in frame 2, stop during frame 3
      watch(1'b0, 2, FRAME_CYC + 100, 3);

      // reset in the middle of an active line
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         @(negedge clk);
         if (hs && data != '0) begin
            seen = 1;
            break;
         end
      end
      chk("hs_seen", 32'(seen), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b0;
      @(negedge clk);
      watch(1'b1, -1, -1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
